// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus microsequencer: opcodes, bus/register bit
// positions, FSM state encoding and instruction classification.
package bus_sequencer_pkg;

  localparam logic [4:0] OP_LDM = 5'h00;
  localparam logic [4:0] OP_MOV = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h0E;
  localparam logic [4:0] OP_DIV = 5'h0F;
  localparam logic [4:0] OP_NOP = 5'h1F;

  localparam int IDX_R0     = 0;
  localparam int IDX_HI     = 16;
  localparam int IDX_LO     = 17;
  localparam int IDX_ZHIGH  = 18;
  localparam int IDX_ZLOW   = 19;
  localparam int IDX_PC     = 20;
  localparam int IDX_MDR    = 21;
  localparam int IDX_INPORT = 22;
  localparam int IDX_Y      = 23;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_Y   = 3'd1,
    S_Z   = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_WBH = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_LDM    = 3'd0,
    CLS_MOV    = 3'd1,
    CLS_MULDIV = 3'd2,
    CLS_ALU    = 3'd3,
    CLS_NOP    = 3'd4
  } iclass_t;

  // Every opcode not listed explicitly is a two-operand ALU operation.
  function automatic iclass_t classify(input logic [4:0] opcode);
    case (opcode)
      OP_LDM:         return CLS_LDM;
      OP_MOV:         return CLS_MOV;
      OP_MUL, OP_DIV: return CLS_MULDIV;
      OP_NOP:         return CLS_NOP;
      default:        return CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/bus_sequencer_onehot_dec4.sv
// 4-bit register field to 16-bit one-hot select.
module onehot_dec4 (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  assign onehot = 16'h0001 << idx;

endmodule

// File: rtl/bus_sequencer.sv
// Microsequencer for the single-bus register-file/ALU datapath: accepts one
// decoded instruction, walks its micro-steps, pulses done on the last one.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [23:0] bus_out_sel,
  output logic [23:0] reg_in_en,
  output logic        Read,
  output logic [4:0]  op,
  output logic        done
);

  // A zero wait would skip the memory step entirely, so clamp into 1..15.
  localparam int MEM_CYC = (MEM_WAIT < 1) ? 1 : ((MEM_WAIT > 15) ? 15 : MEM_WAIT);
  localparam logic [3:0] CNT_LOAD = 4'(MEM_CYC - 1);

  state_t      state, next_state;
  iclass_t     cls;
  logic [4:0]  opcode_q;
  logic [3:0]  ra_q, rb_q, rc_q, cnt;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        accept;
  logic        unused_bits;

  assign unused_bits = ^instr[14:0];
  assign accept      = instr_valid && (state == IDLE);
  assign cls         = classify(opcode_q);
  assign op          = opcode_q;

  onehot_dec4 u_dec_ra (.idx(ra_q), .onehot(ra_oh));
  onehot_dec4 u_dec_rb (.idx(rb_q), .onehot(rb_oh));
  onehot_dec4 u_dec_rc (.idx(rc_q), .onehot(rc_oh));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next_state;
  end

  // Instruction fields stay latched until the next accept so op is stable.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      cnt      <= '0;
    end else if (accept) begin
      opcode_q <= instr[31:27];
      ra_q     <= instr[26:23];
      rb_q     <= instr[22:19];
      rc_q     <= instr[18:15];
      cnt      <= CNT_LOAD;
    end else if (state == S_MEM && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (classify(instr[31:27]))
            CLS_LDM:          next_state = S_MEM;
            CLS_MOV, CLS_NOP: next_state = S_WB;
            default:          next_state = S_Y;
          endcase
        end
      end
      S_Y:     next_state = S_Z;
      S_Z:     next_state = S_WB;
      S_MEM:   next_state = (cnt == 4'd0) ? S_WB : S_MEM;
      S_WB:    next_state = (cls == CLS_MULDIV) ? S_WBH : IDLE;
      S_WBH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus_out_sel = '0;
    reg_in_en   = '0;
    Read        = 1'b0;
    done        = 1'b0;
    instr_ready = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      S_Y: begin
        bus_out_sel        = {8'h00, rb_oh};
        reg_in_en[IDX_Y]   = 1'b1;
      end
      S_Z: begin
        bus_out_sel          = {8'h00, rc_oh};
        reg_in_en[IDX_ZLOW]  = 1'b1;
        reg_in_en[IDX_ZHIGH] = (cls == CLS_MULDIV);
      end
      S_MEM: begin
        Read               = 1'b1;
        reg_in_en[IDX_MDR] = 1'b1;
      end
      S_WB: begin
        done = (cls != CLS_MULDIV);
        case (cls)
          CLS_LDM: begin
            bus_out_sel[IDX_MDR] = 1'b1;
            reg_in_en            = {8'h00, ra_oh};
          end
          CLS_MOV: begin
            bus_out_sel = {8'h00, rb_oh};
            reg_in_en   = {8'h00, ra_oh};
          end
          CLS_MULDIV: begin
            bus_out_sel[IDX_ZLOW] = 1'b1;
            reg_in_en[IDX_LO]     = 1'b1;
          end
          CLS_ALU: begin
            bus_out_sel[IDX_ZLOW] = 1'b1;
            reg_in_en             = {8'h00, ra_oh};
          end
          default: ;
        endcase
      end
      S_WBH: begin
        bus_out_sel[IDX_ZHIGH] = 1'b1;
        reg_in_en[IDX_HI]      = 1'b1;
        done                   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed micro-step tables plus a randomized run
// compared against a per-class micro-step expansion model.
module tb_bus_sequencer;

  localparam int MW = 3;

  logic        clock = 1'b0;
  logic        clear;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [23:0] bus_out_sel;
  logic [23:0] reg_in_en;
  logic        Read;
  logic [4:0]  op;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [23:0] sel;
    logic [23:0] en;
    logic        rd;
    logic        dn;
  } step_t;

  step_t exp_q[$];

  bus_sequencer #(.MEM_WAIT(MW)) dut (
    .clock       (clock),
    .clear       (clear),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .bus_out_sel (bus_out_sel),
    .reg_in_en   (reg_in_en),
    .Read        (Read),
    .op          (op),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] oh(input int n);
    logic [23:0] one;
    one = 24'h1;
    return one << n;
  endfunction

  function automatic step_t mk(input logic [23:0] s, input logic [23:0] e,
                               input logic r, input logic d);
    step_t t;
    t.sel = s; t.en = e; t.rd = r; t.dn = d;
    return t;
  endfunction

  // Expected micro-steps for one instruction, written from the class rules.
  task automatic model(input logic [4:0] opc, input int ra, input int rb, input int rc);
    bit md;
    exp_q.delete();
    md = (opc == 5'h0E) || (opc == 5'h0F);
    if (opc == 5'h00) begin
      for (int i = 0; i < MW; i++) exp_q.push_back(mk(24'h0, oh(21), 1'b1, 1'b0));
      exp_q.push_back(mk(oh(21), oh(ra), 1'b0, 1'b1));
    end else if (opc == 5'h01) begin
      exp_q.push_back(mk(oh(rb), oh(ra), 1'b0, 1'b1));
    end else if (opc == 5'h1F) begin
      exp_q.push_back(mk(24'h0, 24'h0, 1'b0, 1'b1));
    end else begin
      exp_q.push_back(mk(oh(rb), oh(23), 1'b0, 1'b0));
      exp_q.push_back(mk(oh(rc), oh(19) | (md ? oh(18) : 24'h0), 1'b0, 1'b0));
      if (md) begin
        exp_q.push_back(mk(oh(19), oh(17), 1'b0, 1'b0));
        exp_q.push_back(mk(oh(18), oh(16), 1'b0, 1'b1));
      end else begin
        exp_q.push_back(mk(oh(19), oh(ra), 1'b0, 1'b1));
      end
    end
  endtask

  // Called at 1 time unit after a rising edge with the DUT idle; returns at
  // the same point after the instruction has finished.
  task automatic run(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] rc, input bit hold);
    step_t s;
    chk("idle_ready", 32'(instr_ready), 32'd1);
    chk("idle_sel", 32'(bus_out_sel), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    instr       = {opc, ra, rb, rc, 15'($urandom)};
    instr_valid = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      s           = exp_q[i];
      instr       = $urandom;
      instr_valid = hold ? 1'b1 : 1'($urandom);
      chk("sel", 32'(bus_out_sel), 32'(s.sel));
      chk("en", 32'(reg_in_en), 32'(s.en));
      chk("read", 32'(Read), 32'(s.rd));
      chk("done", 32'(done), 32'(s.dn));
      chk("busy_ready", 32'(instr_ready), 32'd0);
      chk("op", 32'(op), 32'(opc));
      chk("onehot", 32'($onehot0(bus_out_sel)), 32'd1);
      @(posedge clock); #1;
    end
    instr_valid = 1'b0;
    chk("end_ready", 32'(instr_ready), 32'd1);
    chk("end_done", 32'(done), 32'd0);
    chk("end_op", 32'(op), 32'(opc));
  endtask

  initial begin
    logic [4:0] ropc;
    logic [3:0] rra, rrb, rrc;

    clear       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_sel", 32'(bus_out_sel), 32'd0);
    chk("rst_en", 32'(reg_in_en), 32'd0);
    chk("rst_read", 32'(Read), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;

    // ALU add r1 <= r2 op r3
    exp_q.delete();
    exp_q.push_back(mk(24'h000004, 24'h800000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h000008, 24'h080000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h080000, 24'h000002, 1'b0, 1'b1));
    run(5'h03, 4'd1, 4'd2, 4'd3, 1'b0);

    // MUL rb=4 rc=5
    exp_q.delete();
    exp_q.push_back(mk(24'h000010, 24'h800000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h000020, 24'h0C0000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h080000, 24'h020000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h040000, 24'h010000, 1'b0, 1'b1));
    run(5'h0E, 4'd0, 4'd4, 4'd5, 1'b0);

    // LDM ra=7 with three memory-wait cycles
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(24'h0, 24'h200000, 1'b1, 1'b0));
    exp_q.push_back(mk(24'h200000, 24'h000080, 1'b0, 1'b1));
    run(5'h00, 4'd7, 4'd0, 4'd0, 1'b0);

    // MOV then NOP back to back, valid held high with junk while busy
    exp_q.delete();
    exp_q.push_back(mk(24'h000400, 24'h000200, 1'b0, 1'b1));
    run(5'h01, 4'd9, 4'd10, 4'd0, 1'b1);
    exp_q.delete();
    exp_q.push_back(mk(24'h0, 24'h0, 1'b0, 1'b1));
    run(5'h1F, 4'd0, 4'd0, 4'd0, 1'b1);

    // Aliased operands ra=rb=rc=6
    exp_q.delete();
    exp_q.push_back(mk(24'h000040, 24'h800000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h000040, 24'h080000, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h080000, 24'h000040, 1'b0, 1'b1));
    run(5'h03, 4'd6, 4'd6, 4'd6, 1'b0);

    // Reset asserted in the middle of S_Z abandons the add
    instr       = {5'h03, 4'd1, 4'd2, 4'd3, 15'd0};
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    chk("pre_rst_sy", 32'(reg_in_en), 32'h800000);
    @(posedge clock); #1;
    chk("pre_rst_sz", 32'(reg_in_en), 32'h080000);
    #2 clear = 1'b0;
    #1;
    chk("midrst_sel", 32'(bus_out_sel), 32'd0);
    chk("midrst_en", 32'(reg_in_en), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("postrst_done", 32'(done), 32'd0);
      chk("postrst_ready", 32'(instr_ready), 32'd1);
      chk("postrst_en", 32'(reg_in_en), 32'd0);
    end

    // Randomized run against the class model
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       ropc = 5'h00;
        1:       ropc = 5'h01;
        2:       ropc = 5'h0E;
        3:       ropc = 5'h0F;
        4:       ropc = 5'h1F;
        default: ropc = 5'($urandom);
      endcase
      rra = 4'($urandom);
      rrb = 4'($urandom);
      rrc = 4'($urandom);
      model(ropc, int'(rra), int'(rrb), int'(rrc));
      run(ropc, rra, rrb, rrc, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Microsequencer that drives the single-bus register-file/ALU datapath: 24 bus-source selects, 24 register load enables, memory Read, and the ALU opcode.
- Accepts one decoded instruction word at a time over a valid/ready handshake.
- Steps through a fixed micro-step sequence per instruction class, then pulses done.
- Sits between instruction fetch/decode logic and the datapath.

Parameters:
- MEM_WAIT, 1, cycles Read/MDRin held in the memory step (1..15).
- OP_LDM, 5'h00, opcode: load MDataIn into Ra via MDR.
- OP_MOV, 5'h01, opcode: Ra <= Rb.
- OP_MUL, 5'h0E, opcode: 64-bit result to HI/LO.
- OP_DIV, 5'h0F, opcode: 64-bit result to HI/LO.
- OP_NOP, 5'h1F, opcode: no bus activity.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- instr_valid  in  1  instr holds a valid instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  fields: opcode[31:27], ra[26:23], rb[22:19], rc[18:15]; bits [14:0] are ignored.
- bus_out_sel  out  24  one-hot bus source select.
- reg_in_en  out  24  register load enables.
- Read  out  1  MDR loads from MDataIn rather than the bus.
- op  out  5  ALU opcode.
- done  out  1  one-cycle pulse on the final micro-step.

Both 24-bit vectors use this bit index: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 Y.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, latched fields=0, all outputs 0 except instr_ready=1. Taking effect mid-instruction abandons it with no done.
- States: IDLE, S_Y, S_Z, S_MEM, S_WB, S_WBH. Outputs are decoded combinationally from the registered state and latched fields only, never from instr.
- instr_ready=1 only in IDLE. Accept on instr_valid&&instr_ready: latch opcode/ra/rb/rc; op <= opcode, held until the next accept.
- Transitions from IDLE on accept:
  - LDM -> S_MEM.
  - MOV -> S_WB.
  - NOP -> S_WB.
  - MUL, DIV and every other opcode -> S_Y.
- S_Y: bus_out_sel[rb]=1, reg_in_en[23]=1 (Y). Next: S_Z.
- S_Z: bus_out_sel[rc]=1, reg_in_en[19]=1; MUL/DIV also reg_in_en[18]=1. Next: S_WB.
- S_MEM: Read=1, reg_in_en[21]=1, no bus source. Held MEM_WAIT cycles via a down-counter loaded on entry. Next: S_WB.
- S_WB by class:
  - LDM: bus_out_sel[21], reg_in_en[ra].
  - MOV: bus_out_sel[rb], reg_in_en[ra].
  - MUL/DIV: bus_out_sel[19], reg_in_en[17] (LO).
  - ALU: bus_out_sel[19], reg_in_en[ra].
  - NOP: no enables.
  - Next: S_WBH for MUL/DIV, else IDLE.
- S_WBH: bus_out_sel[18], reg_in_en[16] (HI). Next: IDLE.
- done=1 in the last micro-step cycle: S_WB for non-MUL/DIV, S_WBH for MUL/DIV.
- Latency from accept cycle to done cycle:
  - ALU 3.
  - MUL/DIV 4.
  - LDM MEM_WAIT+1.
  - MOV/NOP 1.
  - A new instruction is accepted no earlier than the cycle after done.
- Invariants:
  - bus_out_sel is zero or one-hot in every cycle.
  - PC, InPort and R-field aliasing need no special handling: ra=rb=rc is legal and Y buffers the first operand.
  - R0 is writable.
- instr_valid in a non-IDLE state is ignored and not queued.
- MEM_WAIT=0 is out of range; the implementation clamps it to 1.

Decomposition:
- Shared package: opcode constants; the 24 bus-index constants (IDX_R0..IDX_Y); the state encoding.
- One sub-module is natural, onehot_dec4 (4-bit field to 16-bit one-hot), instantiated for rb, rc and ra.
- The rest is a single FSM module, 150-250 lines.

Test Plan:
- Reset: assert clear=0 mid-S_Z of an add -> next observed cycle all selects/enables 0, instr_ready=1, done never asserted.
- ALU: op=5'h03, ra=1, rb=2, rc=3 ->
  - cycle1 bus_out_sel=0x000004, reg_in_en=0x800000;
  - cycle2 bus_out_sel=0x000008, reg_in_en=0x080000, op=3;
  - cycle3 bus_out_sel=0x080000, reg_in_en=0x000002, done=1;
  - cycle4 instr_ready=1.
- MUL: op=5'h0E, rb=4, rc=5 ->
  - S_Z reg_in_en=0x0C0000;
  - S_WB bus_out_sel=0x080000, reg_in_en=0x020000;
  - S_WBH bus_out_sel=0x040000, reg_in_en=0x010000, done=1.
- LDM with MEM_WAIT=3, ra=7 -> Read=1 and reg_in_en=0x200000 for exactly 3 cycles, then bus_out_sel=0x200000, reg_in_en=0x000080, done=1.
- Back-to-back: instr_valid held high with MOV (ra=9, rb=10) then NOP ->
  - MOV done one cycle after accept (bus_out_sel=0x000400, reg_in_en=0x000200);
  - NOP accepted in the following IDLE cycle, done with all enables 0;
  - an instr change while busy has no effect.
- Aliasing: add with ra=rb=rc=6 -> S_Y sel bit6 + Y, S_Z sel bit6 + Zlow, S_WB Zlow to R6; assertion checks bus_out_sel one-hot in every cycle of a 1000-instruction random run.
